serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin one subtraction.
REQ-005 The block SHALL have port A, input, WIDTH, minuend.
REQ-006 The block SHALL have port B, input, WIDTH, subtrahend.
REQ-007 The block SHALL have port Bin, input, 1, borrow-in.
REQ-008 The block SHALL have port Diff, output, WIDTH, registered difference.
REQ-009 The block SHALL have port Borrow, output, 1, registered borrow-out.
REQ-010 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-012 The block SHALL compute A - B - Bin bit-serially, LSB first, using one full-subtractor bit slice per cycle: d = a^b^br; br_next = (~a&b)|(~a&br)|(b&br).
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE, with a bit counter of width clog2(WIDTH)+1.
REQ-014 In IDLE, when start=1 at a clock edge, the block SHALL capture A, B and Bin into internal shift and borrow registers, clear the counter and go to RUN. Diff and Borrow hold their previous values until completion.
REQ-015 In RUN, each edge SHALL process one bit: shift the operands right, shift the result bit into the MSB of the result register, update the borrow register and increment the counter.
REQ-016 On the edge that processes bit WIDTH-1, the block SHALL load Diff with the full result and Borrow with the final borrow, and go to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency: with start sampled at edge k, done SHALL be high during the cycle after edge k+WIDTH, and Diff/Borrow SHALL be valid from that cycle.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE; done SHALL be 1 only in DONE.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing of requests.
REQ-021 Changes on A, B or Bin after capture SHALL NOT affect the operation in progress.
REQ-022 Diff and Borrow SHALL hold their value from the last completion until the next completion or reset.
REQ-023 Arithmetic: Diff SHALL equal (A - B - Bin) mod 2^WIDTH, and Borrow SHALL be 1 if and only if A < B + Bin (unsigned).
REQ-024 start held high continuously SHALL start a new operation on the first IDLE edge after DONE, giving back-to-back operations every WIDTH+2 cycles.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear to 0: Diff, Borrow, busy, done, the counter, and the shift and borrow registers.
REQ-026 Reset SHALL take priority over start and over any in-progress operation. An aborted operation produces no done pulse, and Diff/Borrow read 0.
REQ-027 On the first edge with rst_n=1, start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 The bench SHALL cover: A=0x35, B=0x12, Bin=0, start pulse -> done exactly 8 cycles after the start edge; Diff=0x23, Borrow=0.
REQ-029 The bench SHALL cover: A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Borrow=1.
REQ-030 The bench SHALL cover: A=0x80, B=0x7F, Bin=1 -> Diff=0x00, Borrow=0; and A=0xFF, B=0xFF, Bin=1 -> Diff=0xFF, Borrow=1.
REQ-031 The bench SHALL cover: start with A=0x10, B=0x01, then start re-pulsed with changed A/B at cycle 3 -> second start ignored; Diff=0x0F, and exactly one done pulse.
REQ-032 The bench SHALL cover: rst_n=0 asserted at cycle 4 of RUN -> next cycle busy=0, done=0, Diff=0x00, Borrow=0, and no done pulse afterwards; a new start then completes correctly.
REQ-033 The bench SHALL cover: start held high for 3 operations -> done pulses spaced WIDTH+2=10 cycles apart, and every result matches a reference model of A-B-Bin.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB
//   first, with a single full-subtractor slice. A start in IDLE captures
//   the operands. WIDTH cycles of RUN follow, and then one DONE cycle
//   pulses done. Diff/Borrow are registered and hold the last completed
//   result until the next completion or reset.
//
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   begin one subtraction (ignored unless IDLE)
//   A       in   [WIDTH] minuend
//   B       in   [WIDTH] subtrahend
//   Bin     in   borrow-in
//   Diff    out  [WIDTH] registered difference
//   Borrow  out  registered borrow-out
//   busy    out  high in RUN and DONE
//   done    out  one-cycle completion pulse (DONE state)
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full-subtractor slice on the current LSBs of the operand shifters.
  logic d_bit;
  logic br_nx;
  logic last_bit;

  assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nx    = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_nx;
        cnt_d = cnt_q + 1'b1;
        // The final slice is written straight to Diff so the result is
        // visible in the DONE cycle, not one cycle later.
        if (last_bit) begin
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = br_nx;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl
//   Scoreboard bench for serial_sub_ctrl (WIDTH=8). A posedge reference
//   model watches the driven inputs and, on every accepted start, queues
//   the arithmetic result together with the cycle it must appear in. A
//   negedge monitor compares done/busy/Diff/Borrow against that model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         Bin   = 1'b0;
  logic [W-1:0] Diff;
  logic         Borrow;
  logic         busy;
  logic         done;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Diff  (Diff),
    .Borrow(Borrow),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc    = 0;
  int           tests  = 0;
  int           fails  = 0;
  bit           active = 1'b0;
  int           k_cur  = 0;
  logic [W-1:0] hold_diff = '0;
  logic         hold_br   = 1'b0;
  int           m_full;
  exp_t         m_e;
  exp_t         p_e;
  bit           exp_done;
  bit           exp_busy;

  task automatic check_bit(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%02h, expected 0x%02h", name, cyc, act, req);
    end
  endtask

  // Reference model: an operation accepted at edge k finishes with done
  // during the cycle after edge k+W; the block is free again at k+W+2.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      active    = 1'b0;
      hold_diff = '0;
      hold_br   = 1'b0;
    end else if (start && (!active || cyc >= k_cur + W + 2)) begin
      m_full     = int'(A) - int'(B) - int'(Bin);
      m_e.diff   = m_full[W-1:0];
      m_e.borrow = (m_full < 0);
      m_e.due    = cyc + W;
      q.push_back(m_e);
      active = 1'b1;
      k_cur  = cyc;
    end
  end

  // Monitor.
  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      exp_busy = active && (cyc >= k_cur) && (cyc <= k_cur + W);
      check_bit("done", done, exp_done);
      check_bit("busy", busy, exp_busy);
      if (exp_done) begin
        p_e       = q.pop_front();
        hold_diff = p_e.diff;
        hold_br   = p_e.borrow;
      end
      check_vec("Diff", Diff, hold_diff);
      check_bit("Borrow", Borrow, hold_br);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    A     = a;
    B     = b;
    Bin   = bi;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Directed arithmetic cases.
    issue(8'h35, 8'h12, 1'b0); tick(12);
    issue(8'h00, 8'h01, 1'b0); tick(12);
    issue(8'h80, 8'h7F, 1'b1); tick(12);
    issue(8'hFF, 8'hFF, 1'b1); tick(12);

    // Re-pulsed start and operand changes during RUN must be ignored.
    issue(8'h10, 8'h01, 1'b0);
    tick(2);
    issue(8'h55, 8'h22, 1'b1);
    A = 8'hAA; B = 8'h33; Bin = 1'b1;
    tick(12);

    // Reset in the fourth RUN cycle aborts the operation.
    issue(8'h9C, 8'h47, 1'b0);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(12);
    issue(8'h9C, 8'h47, 1'b1); tick(12);

    // start held high: three back-to-back operations, operands changing
    // every cycle so each capture edge is exercised.
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      A   = W'($urandom);
      B   = W'($urandom);
      Bin = 1'($urandom);
      tick(1);
    end
    start = 1'b0;
    tick(12);

    // Random operations with random gaps (some land while busy).
    for (int i = 0; i < 24; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      tick($urandom_range(2, 13));
    end
    tick(16);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still outstanding, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
